cva6_store_mem_responder: RTL and testbench
===========================================

CVA6_STORE_MEM_RESPONDER -- requirements
Module: cva6_store_mem_responder

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the maximum number of outstanding granted stores (power of two, 2..8).
REQ-002 Parameter LATENCY, default 3, SHALL set the cycles from grant edge to response (legal range 1..15).
REQ-003 clk_i  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 store_req_i  input  1  SHALL indicate that a store request is presented this cycle.
REQ-006 store_addr_i  input  32  SHALL be the store address, valid when store_req_i=1.
REQ-007 stall_i  input  1  SHALL, when 1, block response issue (cache busy).
REQ-008 store_gnt_o  output  1  SHALL indicate that the request is accepted at the coming edge.
REQ-009 store_mem_resp_o  output  1  SHALL be a one-cycle completion pulse per granted store.
REQ-010 resp_addr_o  output  32  SHALL carry the address of the completing store while store_mem_resp_o=1, else 0.
REQ-011 outstanding_o  output  4  SHALL equal the current number of occupied entries.
REQ-012 resp_count_o  output  32  SHALL count total responses issued, wrapping modulo 2^32.

Function
REQ-013 Storage SHALL be an in-order FIFO of DEPTH entries {valid, addr[31:0], cnt[3:0]}, with head/tail pointers of width log2(DEPTH) that wrap naturally.
REQ-014 store_gnt_o SHALL be combinational: store_req_i AND (outstanding_o < DEPTH). There is no same-cycle bypass: a pop does not free space for a push at the same edge.
REQ-015 On an edge with store_req_i=1 and store_gnt_o=1, the tail entry SHALL load valid=1, addr=store_addr_i, cnt=LATENCY-1, and the tail SHALL advance.
REQ-016 At every edge, every valid entry other than one pushed at that edge SHALL decrement cnt, saturating at 0; decrement SHALL continue while stall_i=1.
REQ-017 Issue condition, evaluated on pre-edge state: head valid AND head cnt==0 AND stall_i==0.
REQ-018 When the issue condition holds at an edge, store_mem_resp_o SHALL be registered 1 and resp_addr_o set to the head addr; the head SHALL clear and advance, and resp_count_o SHALL increment. Otherwise store_mem_resp_o and resp_addr_o SHALL register 0.
REQ-019 At most one response SHALL issue per cycle; responses SHALL be strictly in grant order, even when younger entries reach cnt==0 first.
REQ-020 Resulting latency: a store granted at edge k SHALL give store_mem_resp_o=1 in the cycle after edge k+LATENCY, provided there is no stall and no older backlog.
REQ-021 Simultaneous push and pop SHALL leave outstanding_o unchanged. Push only: +1. Pop only: -1.
REQ-022 Full (outstanding_o==DEPTH): store_gnt_o SHALL be 0 and store_req_i ignored, with no state change. Empty: no response SHALL issue, whatever stall_i is.
REQ-023 store_req_i without grant SHALL have no effect; the requester holds the request until granted.

Reset
REQ-024 While rst_ni=0, regardless of clk_i: all entries invalid, pointers=0, cnt=0, store_mem_resp_o=0, resp_addr_o=0, outstanding_o=0, resp_count_o=0, and store_gnt_o forced to 0.
REQ-025 Reset asserted mid-operation SHALL discard all outstanding stores without emitting responses. The first grant is possible in the first cycle after rst_ni rises.

Verification
REQ-026 Single store, LATENCY=3: req addr 0x1000 granted at edge 1 -> resp=1, resp_addr=0x1000 in the cycle after edge 4 only; resp_count=1; outstanding returns to 0.
REQ-027 Fill: req held high with addrs 0x10,0x20,0x30,0x40,0x50 on back-to-back cycles -> first four granted, gnt=0 for 0x50 while outstanding=4; 0x50 granted only after the first pop edge.
REQ-028 Stall: two stores granted, stall_i=1 for 6 cycles -> no resp during stall; after stall drops, resp for the first then the second on consecutive cycles, in order.
REQ-029 Simultaneous push/pop: with outstanding=2 and head issuing on the same edge as a new grant -> outstanding_o stays 2 and the pushed entry gets cnt=LATENCY-1.
REQ-030 Reset mid-flight: 3 outstanding, rst_ni pulsed low between edges -> outputs 0 immediately; no response afterwards; new store after reset completes with nominal latency.
REQ-031 Wrap: 2*DEPTH+1 sequential stores with distinct addrs, LATENCY=1 -> all responses in order with matching addrs; pointers wrap without loss.

Source files
------------

// File: rtl/cva6_store_mem_responder.sv
// rtl/cva6_store_mem_responder.sv - In-order store completion responder with fixed grant-to-response latency
// Each granted store occupies a FIFO slot that counts down and retires strictly in grant order.
module cva6_store_mem_responder #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        store_req_i,
  input  logic [31:0] store_addr_i,
  input  logic        stall_i,
  output logic        store_gnt_o,
  output logic        store_mem_resp_o,
  output logic [31:0] resp_addr_o,
  output logic [3:0]  outstanding_o,
  output logic [31:0] resp_count_o
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam logic [3:0]  DEPTH_L  = 4'(DEPTH);
  localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);

  logic [DEPTH-1:0] r_valid;
  logic [31:0]      r_addr [DEPTH];
  logic [3:0]       r_cnt  [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [3:0]       r_count;
  logic             r_resp;
  logic [31:0]      r_resp_addr;
  logic [31:0]      r_resp_count;

  logic w_push;
  logic w_pop;

  // Grant is gated by reset so nothing is accepted while rst_ni is low.
  always_comb begin
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_push = rst_ni & store_req_i & (r_count < DEPTH_L);
    w_pop  = r_valid[r_head] & (r_cnt[r_head] == 4'd0) & ~stall_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_addr[i]  <= 32'd0;
        r_cnt[i]   <= 4'd0;
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= 4'd0;
      r_resp       <= 1'b0;
      r_resp_addr  <= 32'd0;
      r_resp_count <= 32'd0;
    end else begin
      // Countdown runs regardless of stall; only the retire is held back.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (PW'(i) == r_tail)) begin
          r_valid[i] <= 1'b1;
          r_addr[i]  <= store_addr_i;
          r_cnt[i]   <= LAT_INIT;
        end else if (w_pop && (PW'(i) == r_head)) begin
          r_valid[i] <= 1'b0;
          r_addr[i]  <= 32'd0;
          r_cnt[i]   <= 4'd0;
        end else if (r_valid[i] && (r_cnt[i] != 4'd0)) begin
          r_cnt[i] <= r_cnt[i] - 4'd1;
        end
      end

      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase

      r_resp      <= w_pop;
      r_resp_addr <= w_pop ? r_addr[r_head] : 32'd0;
      if (w_pop) r_resp_count <= r_resp_count + 32'd1;
    end
  end

  assign store_gnt_o      = w_push;
  assign store_mem_resp_o = r_resp;
  assign resp_addr_o      = r_resp_addr;
  assign outstanding_o    = r_count;
  assign resp_count_o     = r_resp_count;

endmodule

// File: tb/tb_cva6_store_mem_responder.sv
// tb/tb_cva6_store_mem_responder.sv - Directed self-checking bench for cva6_store_mem_responder
module tb_cva6_store_mem_responder;

  logic        clk;
  logic        rst_n;

  logic        req, stall;
  logic [31:0] addr;
  logic        gnt, resp;
  logic [31:0] raddr, rcount;
  logic [3:0]  outst;

  logic        req1, stall1;
  logic [31:0] addr1;
  logic        gnt1, resp1;
  logic [31:0] raddr1, rcount1;
  logic [3:0]  outst1;

  int errors = 0;
  int checks = 0;

  cva6_store_mem_responder #(.DEPTH(4), .LATENCY(3)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .store_req_i(req), .store_addr_i(addr), .stall_i(stall),
    .store_gnt_o(gnt), .store_mem_resp_o(resp), .resp_addr_o(raddr),
    .outstanding_o(outst), .resp_count_o(rcount)
  );

  cva6_store_mem_responder #(.DEPTH(4), .LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .rst_ni(rst_n), .store_req_i(req1), .store_addr_i(addr1), .stall_i(stall1),
    .store_gnt_o(gnt1), .store_mem_resp_o(resp1), .resp_addr_o(raddr1),
    .outstanding_o(outst1), .resp_count_o(rcount1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b1; addr = 32'hDEAD; stall = 1'b0;
    req1 = 1'b0; addr1 = 32'd0; stall1 = 1'b0;
    step(); step();
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b exp 0", gnt); end
    checks++; if (resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b exp 0", resp); end
    checks++; if (raddr !== 32'd0) begin errors++; $display("FAIL reset_raddr: got %h exp 0", raddr); end
    checks++; if (outst !== 4'd0) begin errors++; $display("FAIL reset_outst: got %0d exp 0", outst); end
    checks++; if (rcount !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", rcount); end
    req = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    req = 1'b1; addr = 32'h1000;
    #1;
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b exp 1", gnt); end
    step();
    req = 1'b0;
    checks++; if (outst !== 4'd1) begin errors++; $display("FAIL single_outst1: got %0d exp 1", outst); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (resp !== 1'b0) begin errors++; $display("FAIL single_early_resp%0d: got %b exp 0", i, resp); end
      step();
    end
    checks++; if (resp !== 1'b1) begin errors++; $display("FAIL single_resp: got %b exp 1", resp); end
    checks++; if (raddr !== 32'h1000) begin errors++; $display("FAIL single_raddr: got %h exp 00001000", raddr); end
    checks++; if (rcount !== 32'd1) begin errors++; $display("FAIL single_count: got %0d exp 1", rcount); end
    checks++; if (outst !== 4'd0) begin errors++; $display("FAIL single_outst0: got %0d exp 0", outst); end
    step();
    checks++; if (resp !== 1'b0 || raddr !== 32'd0) begin errors++; $display("FAIL single_after: got resp=%b addr=%h exp 0/0", resp, raddr); end
  endtask

  task automatic test_fill();
    logic [31:0] exp_a [5];
    exp_a[0] = 32'h10; exp_a[1] = 32'h20; exp_a[2] = 32'h30; exp_a[3] = 32'h40; exp_a[4] = 32'h50;
    stall = 1'b1;
    req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = exp_a[i];
      #1;
      checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL fill_gnt%0d: got %b exp 1", i, gnt); end
      step();
    end
    addr = 32'h50;
    #1;
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL fill_full_gnt: got %b exp 0", gnt); end
    checks++; if (outst !== 4'd4) begin errors++; $display("FAIL fill_outst4: got %0d exp 4", outst); end
    step();
    checks++; if (outst !== 4'd4 || resp !== 1'b0) begin errors++; $display("FAIL fill_hold: got outst=%0d resp=%b exp 4/0", outst, resp); end
    stall = 1'b0;
    #1;
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL fill_no_bypass: got %b exp 0", gnt); end
    step();
    checks++; if (resp !== 1'b1 || raddr !== 32'h10) begin errors++; $display("FAIL fill_pop0: got resp=%b addr=%h exp 1/10", resp, raddr); end
    checks++; if (outst !== 4'd3) begin errors++; $display("FAIL fill_outst3: got %0d exp 3", outst); end
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL fill_gnt50: got %b exp 1", gnt); end
    step();
    req = 1'b0;
    for (int i = 1; i < 5; i++) begin
      checks++; if (resp !== 1'b1 || raddr !== exp_a[i]) begin errors++; $display("FAIL fill_order%0d: got resp=%b addr=%h exp 1/%h", i, resp, raddr, exp_a[i]); end
      step();
    end
    checks++; if (rcount !== 32'd6) begin errors++; $display("FAIL fill_count: got %0d exp 6", rcount); end
    checks++; if (outst !== 4'd0) begin errors++; $display("FAIL fill_outst0: got %0d exp 0", outst); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    req = 1'b1; addr = 32'hA0;
    step();
    addr = 32'hB0;
    step();
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (resp !== 1'b0) begin errors++; $display("FAIL stall_resp%0d: got %b exp 0", i, resp); end
      step();
    end
    checks++; if (resp !== 1'b0 || outst !== 4'd2) begin errors++; $display("FAIL stall_end: got resp=%b outst=%0d exp 0/2", resp, outst); end
    stall = 1'b0;
    step();
    checks++; if (resp !== 1'b1 || raddr !== 32'hA0) begin errors++; $display("FAIL stall_first: got resp=%b addr=%h exp 1/a0", resp, raddr); end
    step();
    checks++; if (resp !== 1'b1 || raddr !== 32'hB0) begin errors++; $display("FAIL stall_second: got resp=%b addr=%h exp 1/b0", resp, raddr); end
    step();
    checks++; if (resp !== 1'b0 || rcount !== 32'd8) begin errors++; $display("FAIL stall_done: got resp=%b count=%0d exp 0/8", resp, rcount); end
  endtask

  task automatic test_push_pop();
    req = 1'b1; addr = 32'hC0;
    step();
    addr = 32'hD0;
    step();
    req = 1'b0;
    step();
    req = 1'b1; addr = 32'hE0;
    #1;
    checks++; if (gnt !== 1'b1 || outst !== 4'd2) begin errors++; $display("FAIL pp_pre: got gnt=%b outst=%0d exp 1/2", gnt, outst); end
    step();
    req = 1'b0;
    checks++; if (resp !== 1'b1 || raddr !== 32'hC0) begin errors++; $display("FAIL pp_pop: got resp=%b addr=%h exp 1/c0", resp, raddr); end
    checks++; if (outst !== 4'd2) begin errors++; $display("FAIL pp_outst: got %0d exp 2", outst); end
    step();
    checks++; if (resp !== 1'b1 || raddr !== 32'hD0 || outst !== 4'd1) begin errors++; $display("FAIL pp_d0: got resp=%b addr=%h outst=%0d exp 1/d0/1", resp, raddr, outst); end
    step();
    checks++; if (resp !== 1'b0) begin errors++; $display("FAIL pp_gap: got %b exp 0", resp); end
    step();
    checks++; if (resp !== 1'b1 || raddr !== 32'hE0 || outst !== 4'd0) begin errors++; $display("FAIL pp_e0: got resp=%b addr=%h outst=%0d exp 1/e0/0", resp, raddr, outst); end
    checks++; if (rcount !== 32'd11) begin errors++; $display("FAIL pp_count: got %0d exp 11", rcount); end
    step();
  endtask

  task automatic test_reset_midflight();
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 32'hF0 + 32'(i);
      step();
    end
    checks++; if (outst !== 4'd3) begin errors++; $display("FAIL rst_pre_outst: got %0d exp 3", outst); end
    rst_n = 1'b0;
    #1;
    checks++; if (outst !== 4'd0 || rcount !== 32'd0) begin errors++; $display("FAIL rst_async: got outst=%0d count=%0d exp 0/0", outst, rcount); end
    checks++; if (gnt !== 1'b0 || resp !== 1'b0) begin errors++; $display("FAIL rst_outputs: got gnt=%b resp=%b exp 0/0", gnt, resp); end
    req = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (resp !== 1'b0) begin errors++; $display("FAIL rst_no_resp%0d: got %b exp 0", i, resp); end
    end
    req = 1'b1; addr = 32'h2000;
    #1;
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL rst_new_gnt: got %b exp 1", gnt); end
    step();
    req = 1'b0;
    step(); step();
    checks++; if (resp !== 1'b0) begin errors++; $display("FAIL rst_new_early: got %b exp 0", resp); end
    step();
    checks++; if (resp !== 1'b1 || raddr !== 32'h2000 || rcount !== 32'd1) begin errors++; $display("FAIL rst_new_resp: got resp=%b addr=%h count=%0d exp 1/2000/1", resp, raddr, rcount); end
    step();
  endtask

  task automatic test_wrap();
    req1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      addr1 = 32'h100 + 32'(i * 4);
      #1;
      checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL wrap_gnt%0d: got %b exp 1", i, gnt1); end
      step();
      if (i > 0) begin
        checks++; if (resp1 !== 1'b1 || raddr1 !== 32'h100 + 32'((i - 1) * 4)) begin errors++; $display("FAIL wrap_resp%0d: got resp=%b addr=%h exp 1/%h", i - 1, resp1, raddr1, 32'h100 + 32'((i - 1) * 4)); end
      end
    end
    req1 = 1'b0;
    step();
    checks++; if (resp1 !== 1'b1 || raddr1 !== 32'h120) begin errors++; $display("FAIL wrap_last: got resp=%b addr=%h exp 1/120", resp1, raddr1); end
    step();
    checks++; if (resp1 !== 1'b0 || outst1 !== 4'd0 || rcount1 !== 32'd9) begin errors++; $display("FAIL wrap_done: got resp=%b outst=%0d count=%0d exp 0/0/9", resp1, outst1, rcount1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stall();
    test_push_pop();
    test_reset_midflight();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
